// File: rtl/link_scheduler.sv
// Purpose: half-duplex channel scheduler; buffers cipher blocks, launches them while PTT holds the channel, gates rx.
// Latency: enqueue-to-launch 2 cycles (empty FIFO, tx idle); rx_valid_in to rx_valid_out 1 cycle; all outputs registered.
// Backpressure: tx_busy_in and a 2-cycle post-launch lockout stall launches; a full 2-entry FIFO drops the newest block.
module link_scheduler #(
  parameter int WIDTH          = 128,
  parameter int GUARD_CYCLES   = 1000,
  parameter int RX_HOLD_CYCLES = 200000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ptt_in,
  input  logic             blk_valid_in,
  input  logic [WIDTH-1:0] blk_in,
  input  logic             tx_busy_in,
  output logic             tx_valid_out,
  output logic [WIDTH-1:0] tx_data_out,
  input  logic             rx_valid_in,
  output logic             rx_valid_out,
  output logic             remote_sel_out,
  output logic [2:0]       state_out,
  output logic [7:0]       drop_count_out
);

  typedef enum logic [2:0] {
    S_LISTEN = 3'd0,
    S_RX     = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  // One down-counter serves both the TX guard time and the RX hold time.
  localparam int MAXC = (GUARD_CYCLES > RX_HOLD_CYCLES) ? GUARD_CYCLES : RX_HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 2);
  localparam logic [CW-1:0] C_GUARD = CW'(GUARD_CYCLES);
  localparam logic [CW-1:0] C_HOLD  = CW'(RX_HOLD_CYCLES);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;
  logic [1:0]         r_lock;
  logic [WIDTH-1:0]   r_fifo0;
  logic [WIDTH-1:0]   r_fifo1;
  logic [1:0]         r_fcnt;
  logic               r_tx_vld;
  logic [WIDTH-1:0]   r_tx_dat;
  logic               r_rx_vld;
  logic               r_remote;
  logic [7:0]         r_drop;

  logic w_tx_mode;
  logic w_lock_clr;
  logic w_launch;
  logic w_flush;
  logic w_enq_ok;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign w_tx_mode  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_lock_clr = (r_lock == 2'd0);
  assign w_launch   = w_tx_mode && (r_fcnt != 2'd0) && !tx_busy_in && w_lock_clr;
  // Abandoning the arm phase discards anything queued so a stale block never leaks into a later talk burst.
  assign w_flush    = (r_state == S_ARM) && !ptt_in;
  assign w_enq_ok   = ((r_state == S_ARM) && ptt_in) || (r_state == S_RUN);
  assign w_full     = (r_fcnt == 2'd2);
  // A same-cycle pop frees the slot first, so a full FIFO still accepts the block.
  assign w_push     = blk_valid_in && w_enq_ok && (!w_full || w_launch);
  assign w_drop     = blk_valid_in && w_enq_ok && w_full && !w_launch;

  // State and shared counter registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_LISTEN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic; receive has priority over PTT and there is no barge-in during RX.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_LISTEN: begin
        if (rx_valid_in) begin
          w_next     = S_RX;
          w_cnt_next = C_HOLD;
        end else if (ptt_in) begin
          w_next     = S_ARM;
          w_cnt_next = C_GUARD;
        end
      end
      S_RX: begin
        if (rx_valid_in) begin
          w_cnt_next = C_HOLD;
        end else if (r_cnt <= C_ONE) begin
          w_next     = S_LISTEN;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - C_ONE;
        end
      end
      S_ARM: begin
        if (!ptt_in) begin
          w_next     = S_LISTEN;
          w_cnt_next = '0;
        end else if (r_cnt <= C_ONE) begin
          w_next     = S_RUN;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - C_ONE;
        end
      end
      S_RUN: begin
        if (!ptt_in) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ptt_in) begin
          w_next = S_RUN;
        end else if ((r_fcnt == 2'd0) && !tx_busy_in && w_lock_clr) begin
          w_next = S_LISTEN;
        end
      end
      default: begin
        w_next     = S_LISTEN;
        w_cnt_next = '0;
      end
    endcase
  end

  // Launch lockout: masks tx_busy_in for the two cycles the transmitter needs to raise it.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_lock <= 2'd0;
    end else if (w_launch) begin
      r_lock <= 2'd2;
    end else if (r_lock != 2'd0) begin
      r_lock <= r_lock - 2'd1;
    end
  end

  // Two-entry FIFO with the head always in r_fifo0; pop shifts, push fills the first free slot.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_fcnt  <= 2'd0;
      r_fifo0 <= '0;
      r_fifo1 <= '0;
    end else if (w_flush) begin
      r_fcnt <= 2'd0;
    end else begin
      case ({w_launch, w_push})
        2'b11: begin
          if (r_fcnt == 2'd2) begin
            r_fifo0 <= r_fifo1;
            r_fifo1 <= blk_in;
          end else begin
            r_fifo0 <= blk_in;
          end
        end
        2'b10: begin
          r_fifo0 <= r_fifo1;
          r_fcnt  <= r_fcnt - 2'd1;
        end
        2'b01: begin
          if (r_fcnt == 2'd0) begin
            r_fifo0 <= blk_in;
          end else begin
            r_fifo1 <= blk_in;
          end
          r_fcnt <= r_fcnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: launch strobe/data, echo-suppressed rx strobe, audio select and drop counter.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_tx_vld <= 1'b0;
      r_tx_dat <= '0;
      r_rx_vld <= 1'b0;
      r_remote <= 1'b1;
      r_drop   <= 8'd0;
    end else begin
      r_tx_vld <= w_launch;
      if (w_launch) begin
        r_tx_dat <= r_fifo0;
      end
      r_rx_vld <= rx_valid_in && ((r_state == S_LISTEN) || (r_state == S_RX));
      r_remote <= (w_next == S_LISTEN) || (w_next == S_RX);
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign tx_valid_out   = r_tx_vld;
  assign tx_data_out    = r_tx_dat;
  assign rx_valid_out   = r_rx_vld;
  assign remote_sel_out = r_remote;
  assign state_out      = r_state;
  assign drop_count_out = r_drop;

endmodule

// File: tb/tb_link_scheduler.sv
// Bench for link_scheduler: directed scenarios plus random traffic against a queue-based reference model.
// Launched blocks are checked by a decoupled monitor popping an expected-launch scoreboard.
// Per-cycle outputs (state, select, rx strobe, drops) are compared with the model's predictions.
module tb_link_scheduler;
  localparam int W = 128;
  localparam int G = 4;
  localparam int H = 10;
  localparam int M_LISTEN = 0, M_RX = 1, M_ARM = 2, M_RUN = 3, M_DRAIN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         ptt = 1'b0, blkv = 1'b0, busy = 1'b0, rxv = 1'b0;
  logic [W-1:0] blk = '0;
  logic         tx_valid_out, rx_valid_out, remote_sel_out;
  logic [W-1:0] tx_data_out;
  logic [2:0]   state_out;
  logic [7:0]   drop_count_out;

  link_scheduler #(.WIDTH(W), .GUARD_CYCLES(G), .RX_HOLD_CYCLES(H)) dut (
    .clk_in(clk), .rst_in(rst_n), .ptt_in(ptt), .blk_valid_in(blkv), .blk_in(blk),
    .tx_busy_in(busy), .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out),
    .rx_valid_in(rxv), .rx_valid_out(rx_valid_out), .remote_sel_out(remote_sel_out),
    .state_out(state_out), .drop_count_out(drop_count_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int arm_seen = 0;

  // Reference model: channel mode, FIFO as a queue, timing kept as cycle stamps.
  int           m_st = M_LISTEN;
  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  int           m_drop = 0;
  int           m_cyc = 0;
  int           m_last_launch = -100;
  int           m_last_rx = 0;
  int           m_arm_start = 0;
  logic         m_valid = 1'b0;
  int           exp_st = 0;
  logic         exp_txv = 1'b0, exp_rxv = 1'b0, exp_remote = 1'b1;
  logic [W-1:0] exp_data = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_outputs();
    if (m_valid) begin
      chk("state", W'(state_out), W'(exp_st));
      chk("remote_sel", W'(remote_sel_out), W'(exp_remote));
      chk("rx_valid", W'(rx_valid_out), W'(exp_rxv));
      chk("tx_valid", W'(tx_valid_out), W'(exp_txv));
      chk("tx_data_hold", tx_data_out, exp_data);
      chk("drop_count", W'(drop_count_out), W'(m_drop));
      if (state_out == 3'd2) arm_seen++;
    end
  endtask

  task automatic model_reset();
    m_st = M_LISTEN;
    mq.delete();
    m_drop = 0;
    m_last_launch = m_cyc - 100;
    exp_st = M_LISTEN;
    exp_txv = 1'b0;
    exp_rxv = 1'b0;
    exp_remote = 1'b1;
    exp_data = '0;
    m_valid = 1'b1;
    m_cyc++;
  endtask

  task automatic model_step(input logic p, input logic bv, input logic [W-1:0] b,
                            input logic bz, input logic rx);
    int  nst;
    logic launch;
    logic lock_free;
    lock_free = (m_cyc - m_last_launch) >= 3;
    launch = ((m_st == M_RUN) || (m_st == M_DRAIN)) && (mq.size() > 0) && !bz && lock_free;
    nst = m_st;
    case (m_st)
      M_LISTEN: begin
        if (rx) begin nst = M_RX; m_last_rx = m_cyc; end
        else if (p) begin nst = M_ARM; m_arm_start = m_cyc; end
      end
      M_RX: begin
        if (rx) m_last_rx = m_cyc;
        else if ((m_cyc - m_last_rx) >= H) nst = M_LISTEN;
      end
      M_ARM: begin
        if (!p) nst = M_LISTEN;
        else if ((m_cyc - m_arm_start) >= G) nst = M_RUN;
      end
      M_RUN: if (!p) nst = M_DRAIN;
      default: begin
        if (p) nst = M_RUN;
        else if ((mq.size() == 0) && !bz && lock_free) nst = M_LISTEN;
      end
    endcase
    if (launch) begin
      exp_data = mq.pop_front();
      sb.push_back(exp_data);
      m_last_launch = m_cyc;
    end
    if (bv && (((m_st == M_ARM) && p) || (m_st == M_RUN))) begin
      if (mq.size() < 2) mq.push_back(b);
      else if (m_drop < 255) m_drop++;
    end
    if ((m_st == M_ARM) && !p) mq.delete();
    exp_txv = launch;
    exp_rxv = rx && ((m_st == M_LISTEN) || (m_st == M_RX));
    exp_st = nst;
    exp_remote = (nst == M_LISTEN) || (nst == M_RX);
    m_st = nst;
    m_cyc++;
  endtask

  task automatic step(input logic p, input logic bv, input logic [W-1:0] b,
                      input logic bz, input logic rx);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1; ptt = p; blkv = bv; blk = b; busy = bz; rxv = rx;
    model_step(p, bv, b, bz, rx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0; ptt = 1'b0; blkv = 1'b0; blk = '0; busy = 1'b0; rxv = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n, input logic p, input logic bz);
    for (int i = 0; i < n; i++) step(p, 1'b0, '0, bz, 1'b0);
  endtask

  // Reset, press PTT and hold it through the guard time so the channel is in TX_RUN.
  task automatic to_run(input logic bz);
    do_reset();
    idle(G + 2, 1'b1, bz);
  endtask

  // Monitor: every launch strobe must match the oldest expected launch.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (tx_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL launch_unexpected: got data %0h expected no launch", tx_data_out);
        end else begin
          e = sb.pop_front();
          chk("launch_data", tx_data_out, e);
        end
      end
    end
  end

  initial begin
    logic rp, rb;
    logic [W-1:0] a, b, c, d;

    // Reset mid-TX_RUN with two blocks queued: nothing launches afterwards.
    to_run(1'b1);
    step(1'b1, 1'b1, rand_blk(), 1'b1, 1'b0);
    step(1'b1, 1'b1, rand_blk(), 1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_state", W'(state_out), W'(0));
    chk("rst_remote", W'(remote_sel_out), W'(1));
    chk("rst_tx_valid", W'(tx_valid_out), W'(0));
    chk("rst_drop", W'(drop_count_out), W'(0));
    chk("rst_tx_data", tx_data_out, W'(0));
    idle(6, 1'b0, 1'b0);

    // PTT from LISTEN, block enqueued during the guard time, launched once in TX_RUN.
    do_reset();
    arm_seen = 0;
    a = rand_blk();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, a, 1'b0, 1'b0);
    idle(8, 1'b1, 1'b0);
    chk("arm_len", W'(arm_seen), W'(G));
    chk("launch_A_data", tx_data_out, a);
    idle(6, 1'b0, 1'b0);

    // Busy transmitter, three consecutive blocks: third dropped, then A and B spaced out.
    to_run(1'b1);
    a = rand_blk(); b = rand_blk(); c = rand_blk();
    step(1'b1, 1'b1, a, 1'b1, 1'b0);
    step(1'b1, 1'b1, b, 1'b1, 1'b0);
    step(1'b1, 1'b1, c, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("drop_after_C", W'(drop_count_out), W'(1));
    idle(10, 1'b1, 1'b0);
    chk("last_launch_B", tx_data_out, b);

    // Full FIFO with a push in the same cycle as a pop: accepted, no drop.
    to_run(1'b1);
    step(1'b1, 1'b1, rand_blk(), 1'b1, 1'b0);
    step(1'b1, 1'b1, rand_blk(), 1'b1, 1'b0);
    d = rand_blk();
    step(1'b1, 1'b1, d, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("no_drop_on_pop", W'(drop_count_out), W'(0));
    idle(12, 1'b1, 1'b0);
    chk("pushed_on_pop_launched", tx_data_out, d);

    // Receive wins over PTT; hold timer reloads on each rx block, then TX_ARM with PTT still held.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 30; i++) step(1'b1, 1'b0, '0, 1'b0, (i == 5) || (i == 12));
    idle(4, 1'b0, 1'b0);

    // Release PTT with one queued block; rx pulses during the drain are suppressed.
    to_run(1'b1);
    step(1'b1, 1'b1, rand_blk(), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(6, 1'b0, 1'b0);

    // Random traffic: PTT and busy as slowly changing levels, sparse strobes, rare resets.
    rp = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) rp = ~rp;
      if ($urandom_range(5) == 0) rb = ~rb;
      if ($urandom_range(499) == 0) do_reset();
      else step(rp, $urandom_range(2) == 0, rand_blk(), rb, $urandom_range(29) == 0);
    end
    idle(12, 1'b0, 1'b0);
    chk("scoreboard_empty", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/link_scheduler.md
# link_scheduler

Half-duplex channel scheduler for the walkie-talkie link. It sits between the cipher/tx pair and the rx/decipher pair, sharing the single radio channel between local transmission and reception. It buffers encrypted blocks, launches them into the transmitter only while push-to-talk is held and the channel is free, gates received blocks to the decipher, and selects local or remote audio for the speaker path.

## Interface

Parameters:
- WIDTH, 128: block width in bits (one AES block).
- GUARD_CYCLES, 1000: cycles spent in TX_ARM before transmission starts.
- RX_HOLD_CYCLES, 200000: RX idle time after the last received block before returning to LISTEN.

Ports:
- clk_in  input  1  system clock (98.3 MHz audio clock domain).
- rst_in  input  1  synchronous, active-low reset.
- ptt_in  input  1  debounced push-to-talk level.
- blk_valid_in  input  1  single-cycle strobe: encrypted block available.
- blk_in  input  WIDTH  encrypted block, valid with blk_valid_in.
- tx_busy_in  input  1  transmitter busy.
- tx_valid_out  output  1  single-cycle launch strobe to transmitter.
- tx_data_out  output  WIDTH  block being launched.
- rx_valid_in  input  1  single-cycle strobe: receiver produced a block.
- rx_valid_out  output  1  gated strobe to decipher.
- remote_sel_out  output  1  1 = play remote (deciphered) audio; 0 = local microphone.
- state_out  output  3  current state encoding.
- drop_count_out  output  8  saturating count of blocks dropped on FIFO overflow.

## Operation

- States: LISTEN=0, RX=1, TX_ARM=2, TX_RUN=3, TX_DRAIN=4. Other encodings are unreachable and go to LISTEN.
- LISTEN:
  - rx_valid_in -> RX, load the hold counter with RX_HOLD_CYCLES.
  - Otherwise ptt_in=1 -> TX_ARM, load the guard counter with GUARD_CYCLES.
  - rx_valid_in and ptt_in in the same cycle -> RX. Receive wins.
- RX:
  - Each rx_valid_in reloads the hold counter.
  - When the counter reaches 0 -> LISTEN.
  - ptt_in is ignored; there is no barge-in.
- TX_ARM:
  - The guard counter decrements each cycle; at 0 -> TX_RUN.
  - ptt_in=0 -> LISTEN and the FIFO is flushed.
  - blk_valid_in enqueues; no launches occur.
- TX_RUN:
  - blk_valid_in enqueues into a 2-entry FIFO.
  - ptt_in=0 -> TX_DRAIN.
- TX_DRAIN:
  - blk_valid_in is ignored.
  - ptt_in=1 -> TX_RUN.
  - FIFO empty, tx_busy_in=0 and launch lockout clear -> LISTEN.
- Launch rule, TX_RUN/TX_DRAIN only: FIFO non-empty, tx_busy_in=0 and lockout=0 -> pop head. A launch sets a 2-cycle lockout that covers the transmitter's busy-rise latency.
- FIFO full plus blk_valid_in:
  - Without a pop in the same cycle, the newest block is dropped and drop_count_out increments, saturating at 255.
  - With a pop in the same cycle, the pop happens first and the block is accepted with no drop.
- blk_valid_in in LISTEN/RX is discarded and not counted.
- rx_valid_out: rx_valid_in registered, forced 0 while in TX_ARM/TX_RUN/TX_DRAIN (own echo).
- remote_sel_out: 1 in LISTEN/RX, 0 in TX states. Registered from the next state.
- Reset (rst_in=0 at a clock edge), including mid-transmission:
  - State goes to LISTEN; FIFO, counters and lockout clear.
  - tx_valid_out=0, tx_data_out=0, rx_valid_out=0, remote_sel_out=1, state_out=0, drop_count_out=0.
  - drop_count_out clears only on reset.

## Timing

- All outputs are registered.
- Launch decided in cycle N -> tx_valid_out=1 in N+1 for exactly one cycle. tx_data_out shows the popped block from N+1 until the next launch.
- Earliest next launch: decision in N+3.
- Enqueue at cycle N with empty FIFO, tx idle, state TX_RUN -> tx_valid_out in N+2.
- rx_valid_in at N -> rx_valid_out at N+1.
- state_out and remote_sel_out update the cycle after the transition condition.
- TX_ARM lasts exactly GUARD_CYCLES cycles when ptt_in is held.

## Test plan

- Bench uses GUARD_CYCLES=4, RX_HOLD_CYCLES=10.
- Reset mid-TX_RUN with 2 blocks queued -> next cycle state_out=0, remote_sel_out=1, tx_valid_out=0, drop_count_out=0; no launch after release.
- ptt_in=1 from LISTEN, block A enqueued during TX_ARM, tx_busy_in=0 -> state sequence 0,2(x4),3; A launched with tx_valid_out high for one cycle and tx_data_out=A.
- TX_RUN, tx_busy_in=1, 3 blocks A,B,C on consecutive strobes -> C dropped, drop_count_out=1; after busy falls, A then B launched at least 3 cycles apart.
- Full FIFO, tx_busy_in=0, blk_valid_in in the same cycle as the pop -> no drop; drop_count_out unchanged.
- LISTEN with rx_valid_in and ptt_in rising together -> state RX, rx_valid_out pulses once. Further rx_valid_in at cycles 5 and 12 -> return to LISTEN 10 cycles after the last one, then TX_ARM because ptt is still held.
- ptt_in released in TX_RUN with 1 queued block; rx_valid_in pulses during the drain -> block launched, rx_valid_out stays 0, LISTEN entered once tx_busy_in=0 and lockout has expired.
